// File: rtl/lsu_read_bank_arbiter.sv
// lsu_read_bank_arbiter: per-cycle bank-conflict arbiter in front of the 8x8 read crossbar.
// Grants at most one LSU per bank per cycle, registers conflict-free {sel, Ren} words,
// tracks bank latency for response strobes and counts refused requests.
// Build option: define ARB_RR_EN for per-bank round-robin; without it the highest-index
// candidate wins (same order as the crossbar's own priority) and no pointers exist.
module lsu_read_bank_arbiter #(
  parameter int BANK_LAT = 1,
  parameter int R_Q      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     lsu_req_vld,
  input  logic [23:0]    lsu_req_bank,
  output logic [7:0]     lsu_req_rdy,
  output logic [R_Q-1:0] LSU_R_req_0,
  output logic [R_Q-1:0] LSU_R_req_1,
  output logic [R_Q-1:0] LSU_R_req_2,
  output logic [R_Q-1:0] LSU_R_req_3,
  output logic [R_Q-1:0] LSU_R_req_4,
  output logic [R_Q-1:0] LSU_R_req_5,
  output logic [R_Q-1:0] LSU_R_req_6,
  output logic [R_Q-1:0] LSU_R_req_7,
  output logic [7:0]     lsu_rsp_vld,
  output logic [15:0]    conflict_cnt
);

  logic [7:0][7:0] win_oh;     // one-hot winning LSU per bank
  logic [7:0]      bank_busy;  // bank has at least one candidate this cycle
  logic [2:0]      idle_bank;
  logic [R_Q-1:0]  req_q [8];
  logic [R_Q-1:0]  req_d [8];
  logic [7:0]      ren_vec;
  logic [7:0]      rsp_sr_q [BANK_LAT];
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    logic [7:0] cand;
    logic [2:0] win;

    // Candidate set: valid LSUs whose bank field selects this bank
    always_comb begin
      cand = '0;
      for (int n = 0; n < 8; n++) begin
        cand[n] = lsu_req_vld[n] && (lsu_req_bank[3*n +: 3] == 3'(gi));
      end
    end

`ifdef ARB_RR_EN
    logic [2:0] rr_q;
    logic [2:0] rr_d;

    // Winner is the first candidate at or after the pointer, wrapping 7 -> 0
    always_comb begin
      logic       found;
      logic [2:0] idx;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < 8; off++) begin
        idx = rr_q + 3'(off);
        if (!found && cand[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end

    // Pointer moves just past the winner; idle banks keep their pointer
    always_comb begin
      rr_d = rr_q;
      if (|cand) rr_d = win + 3'd1;
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
    end
`else
    // Fixed priority: highest-index candidate wins, mirroring the crossbar order
    always_comb begin
      win = '0;
      for (int n = 0; n < 8; n++) begin
        if (cand[n]) win = 3'(n);
      end
    end
`endif

    assign bank_busy[gi] = |cand;
    assign win_oh[gi]    = (|cand) ? (8'd1 << win) : 8'd0;
  end

  // Grant vector: union of per-bank winners (each LSU names one bank, so no overlap)
  always_comb begin
    lsu_req_rdy = '0;
    for (int b = 0; b < 8; b++) begin
      lsu_req_rdy = lsu_req_rdy | win_oh[b];
    end
  end

  // Lowest bank nobody is reading this cycle; parked words point there harmlessly
  always_comb begin
    idle_bank = '0;
    for (int b = 7; b >= 0; b--) begin
      if (!bank_busy[b]) idle_bank = 3'(b);
    end
  end

  // Next crossbar words: granted LSUs read their bank, others park on the idle bank
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (lsu_req_rdy[n]) req_d[n] = {lsu_req_bank[3*n +: 3], 1'b1};
      else                req_d[n] = {idle_bank, 1'b0};
    end
  end

  // Crossbar request word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) req_q[n] <= '0;
    end else begin
      for (int n = 0; n < 8; n++) req_q[n] <= req_d[n];
    end
  end

  // Ren bits of the registered words enter the latency pipe
  always_comb begin
    for (int n = 0; n < 8; n++) ren_vec[n] = req_q[n][0];
  end

  // Bank-latency shift register; reset drops every in-flight strobe at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK_LAT; i++) rsp_sr_q[i] <= '0;
    end else begin
      rsp_sr_q[0] <= ren_vec;
      for (int i = 1; i < BANK_LAT; i++) rsp_sr_q[i] <= rsp_sr_q[i-1];
    end
  end

  // Saturating sum of refused requests (vld high, rdy low)
  always_comb begin
    logic [16:0] sum;
    sum = {1'b0, cnt_q};
    for (int n = 0; n < 8; n++) begin
      sum = sum + 17'(lsu_req_vld[n] & ~lsu_req_rdy[n]);
    end
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  // Conflict counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign LSU_R_req_0  = req_q[0];
  assign LSU_R_req_1  = req_q[1];
  assign LSU_R_req_2  = req_q[2];
  assign LSU_R_req_3  = req_q[3];
  assign LSU_R_req_4  = req_q[4];
  assign LSU_R_req_5  = req_q[5];
  assign LSU_R_req_6  = req_q[6];
  assign LSU_R_req_7  = req_q[7];
  assign lsu_rsp_vld  = rsp_sr_q[BANK_LAT-1];
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_lsu_read_bank_arbiter.sv
// Table-driven bench for lsu_read_bank_arbiter (BANK_LAT = 2); expectations follow
// whether ARB_RR_EN is defined for the build.
module tb_lsu_read_bank_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vld = '0;
  logic [23:0] bank = '0;
  logic [7:0]  rdy;
  logic [3:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [7:0]  rsp;
  logic [15:0] cnt;
  logic [3:0]  words [8];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu_read_bank_arbiter #(.BANK_LAT(LAT), .R_Q(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_vld(vld), .lsu_req_bank(bank), .lsu_req_rdy(rdy),
    .LSU_R_req_0(w0), .LSU_R_req_1(w1), .LSU_R_req_2(w2), .LSU_R_req_3(w3),
    .LSU_R_req_4(w4), .LSU_R_req_5(w5), .LSU_R_req_6(w6), .LSU_R_req_7(w7),
    .lsu_rsp_vld(rsp), .conflict_cnt(cnt)
  );

  always_comb begin
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    words[4] = w4; words[5] = w5; words[6] = w6; words[7] = w7;
  end

  typedef struct {
    logic [7:0]  vld;
    logic [23:0] bank;
    logic [7:0]  rdy_rr;
    logic [7:0]  rdy_fp;
  } vec_t;

  vec_t tbl [10];
  logic [7:0] hist [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [23:0] pack8(input int b0, input int b1, input int b2, input int b3,
                                        input int b4, input int b5, input int b6, input int b7);
    logic [23:0] r;
    r = {3'(b7), 3'(b6), 3'(b5), 3'(b4), 3'(b3), 3'(b2), 3'(b1), 3'(b0)};
    return r;
  endfunction

  initial begin
    logic [7:0] er;
    logic [7:0] busy;
    logic [2:0] idle;
    logic [3:0] ew;
    int exp_cnt;

    // rotation (bank3 from LSU1/4/6), distinct banks, idle steering, all-on-bank0, misc
    tbl[0] = '{8'h52, pack8(0,3,0,0,3,0,3,0), 8'h02, 8'h40};
    tbl[1] = '{8'h52, pack8(0,3,0,0,3,0,3,0), 8'h10, 8'h40};
    tbl[2] = '{8'h52, pack8(0,3,0,0,3,0,3,0), 8'h40, 8'h40};
    tbl[3] = '{8'h52, pack8(0,3,0,0,3,0,3,0), 8'h02, 8'h40};
    tbl[4] = '{8'hFF, pack8(7,6,5,4,3,2,1,0), 8'hFF, 8'hFF};
    tbl[5] = '{8'h89, pack8(0,0,0,1,0,0,0,0), 8'h09, 8'h88};
    tbl[6] = '{8'hFF, pack8(0,0,0,0,0,0,0,0), 8'h02, 8'h80};
    tbl[7] = '{8'h00, pack8(0,0,0,0,0,0,0,0), 8'h00, 8'h00};
    tbl[8] = '{8'h2C, pack8(0,0,5,2,0,5,0,0), 8'h28, 8'h28};
    tbl[9] = '{8'h05, pack8(7,0,7,0,0,0,0,0), 8'h04, 8'h04};

    // Reset state
    #3;
    chk("reset_rdy", 32'(rdy), 32'h0);
    chk("reset_rsp", 32'(rsp), 32'h0);
    chk("reset_cnt", 32'(cnt), 32'h0);
    for (int n = 0; n < 8; n++) chk($sformatf("reset_word%0d", n), 32'(words[n]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vld  = tbl[i].vld;
      bank = tbl[i].bank;
`ifdef ARB_RR_EN
      er = tbl[i].rdy_rr;
`else
      er = tbl[i].rdy_fp;
`endif
      #1;
      chk($sformatf("rdy_v%0d", i), 32'(rdy), 32'(er));
      exp_cnt += $countones(vld & ~er);
      hist[i] = er;
      busy = '0;
      for (int n = 0; n < 8; n++) if (er[n]) busy[bank[3*n +: 3]] = 1'b1;
      idle = '0;
      for (int b = 7; b >= 0; b--) if (!busy[b]) idle = 3'(b);
      $display("vec %0d vld=%02h bank=%06h rdy=%02h exp_rdy=%02h", i, vld, bank, rdy, er);
      @(posedge clk);
      #1;
      for (int n = 0; n < 8; n++) begin
        ew = er[n] ? {bank[3*n +: 3], 1'b1} : {idle, 1'b0};
        chk($sformatf("word_v%0d_lsu%0d", i, n), 32'(words[n]), 32'(ew));
      end
      chk($sformatf("cnt_v%0d", i), 32'(cnt), 32'(exp_cnt));
      chk($sformatf("rsp_v%0d", i), 32'(rsp), (i >= LAT) ? 32'(hist[i-LAT]) : 32'h0);
    end

    // Drain the latency pipe
    for (int j = 10; j < 10 + LAT; j++) begin
      @(negedge clk);
      vld = '0;
      @(posedge clk);
      #1;
      chk($sformatf("rsp_drain%0d", j), 32'(rsp), 32'(hist[j-LAT]));
      $display("drain %0d rsp=%02h", j, rsp);
    end

    // Reset mid-flight: LSU2 -> bank5 accepted, reset before its strobe appears
    @(negedge clk);
    vld  = 8'h04;
    bank = pack8(0,0,5,0,0,0,0,0);
    #1 chk("midrst_rdy", 32'(rdy), 32'h04);
    @(posedge clk);
    #1 chk("midrst_word2", 32'(w2), 32'hB);
    @(negedge clk);
    vld = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp", 32'(rsp), 32'h0);
    chk("midrst_cnt", 32'(cnt), 32'h0);
    for (int n = 0; n < 8; n++) chk($sformatf("midrst_word%0d", n), 32'(words[n]), 32'h0);
    $display("mid-stream reset applied rsp=%02h cnt=%0d", rsp, cnt);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk($sformatf("midrst_norsp%0d", k), 32'(rsp[2]), 32'h0);
    end

    // Counter saturation: 7 refusals per cycle, 9362*7 = 65534, then clamp
    @(negedge clk);
    vld  = 8'hFF;
    bank = '0;
    repeat (9362) @(posedge clk);
    #1 chk("sat_pre", 32'(cnt), 32'd65534);
    @(posedge clk);
    #1 chk("sat_hit", 32'(cnt), 32'hFFFF);
    @(posedge clk);
    #1 chk("sat_hold", 32'(cnt), 32'hFFFF);
    $display("saturation cnt=%04h", cnt);
    @(negedge clk);
    vld = '0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
